// File: rtl/rf_arb_pkg.sv
// Shared constants, slot types and helpers for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned NREG     = 32;
  localparam int unsigned DW       = 64;
  localparam int unsigned RW       = $clog2(NREG);
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned CNT_W    = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    slot_state_e   state;
    logic [RW-1:0] wreg;
    logic [DW-1:0] data;
  } slot_t;

  // One-hot decode of a register index.
  function automatic logic [NREG-1:0] reg_onehot(input logic [RW-1:0] r);
    logic [NREG-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a writeback requester: EMPTY/FULL FSM,
// capture registers and ready generation.
module rf_wr_slot
  import rf_arb_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          valid,
  input  logic [RW-1:0] wreg_in,
  input  logic [DW-1:0] data_in,
  input  logic          grant,
  output logic          ready_c,
  output logic          fill_c,
  output slot_t         slot
);

  slot_t slot_q;
  slot_t slot_d;

  // Ready/fill decode and next-slot computation; zero-register writes are
  // acknowledged but never captured.
  always_comb begin
    ready_c = 1'b0;
    fill_c  = 1'b0;
    slot_d  = slot_q;
    if (!reset) begin
      ready_c = (slot_q.state == SLOT_EMPTY) || grant;
    end
    fill_c = valid && ready_c && (wreg_in != RW'(ZERO_REG));
    if (fill_c) begin
      slot_d.state = SLOT_FULL;
      slot_d.wreg  = wreg_in;
      slot_d.data  = data_in;
    end else if (grant) begin
      slot_d.state = SLOT_EMPTY;
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback requesters (A: ALU, B: load) onto the single
// register-file write port and exports a per-register pending-write vector.
// Optional statistics counters are enabled with RF_WR_STATS_EN.
module regfile_write_arbiter
  import rf_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             AValid,
  output logic             AReady,
  input  logic [RW-1:0]    AReg,
  input  logic [DW-1:0]    AData,
  input  logic             BValid,
  output logic             BReady,
  input  logic [RW-1:0]    BReg,
  input  logic [DW-1:0]    BData,
  output logic             RegWrite,
  output logic [RW-1:0]    WriteReg,
  output logic [DW-1:0]    WriteData,
  output logic [NREG-1:0]  Busy
`ifdef RF_WR_STATS_EN
  ,
  output logic [CNT_W-1:0] WriteCount,
  output logic [CNT_W-1:0] ConflictCount
`endif
);

  slot_t slot_a;
  slot_t slot_b;
  logic  fill_a;
  logic  fill_b;
  logic  grant_a;
  logic  grant_b;
  logic  a_full;
  logic  b_full;
  logic  ptr_q;
  logic  ptr_d;
  logic  older_a_q;
  logic  older_a_d;

  rf_wr_slot u_slot_a (
    .clock   (clock),
    .reset   (reset),
    .valid   (AValid),
    .wreg_in (AReg),
    .data_in (AData),
    .grant   (grant_a),
    .ready_c (AReady),
    .fill_c  (fill_a),
    .slot    (slot_a)
  );

  rf_wr_slot u_slot_b (
    .clock   (clock),
    .reset   (reset),
    .valid   (BValid),
    .wreg_in (BReg),
    .data_in (BData),
    .grant   (grant_b),
    .ready_c (BReady),
    .fill_c  (fill_b),
    .slot    (slot_b)
  );

  assign a_full = (slot_a.state == SLOT_FULL);
  assign b_full = (slot_b.state == SLOT_FULL);

  // Grant from registered state: age wins on same register, else round robin.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (!reset) begin
      if (a_full && b_full) begin
        if (slot_a.wreg == slot_b.wreg) begin
          grant_a = older_a_q;
          grant_b = !older_a_q;
        end else begin
          grant_a = (ptr_q == REQ_A);
          grant_b = (ptr_q == REQ_B);
          ptr_d   = (ptr_q == REQ_A) ? REQ_B : REQ_A;
        end
      end else begin
        grant_a = a_full;
        grant_b = b_full;
      end
    end
  end

  // Age tracking: a slot already holding an undrained write is the older one.
  always_comb begin
    older_a_d = older_a_q;
    if (fill_a && fill_b) begin
      older_a_d = 1'b1;
    end else if (fill_a && b_full && !grant_b) begin
      older_a_d = 1'b0;
    end else if (fill_b && a_full && !grant_a) begin
      older_a_d = 1'b1;
    end
  end

  // Round-robin pointer and age bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q     <= REQ_A;
      older_a_q <= 1'b1;
    end else begin
      ptr_q     <= ptr_d;
      older_a_q <= older_a_d;
    end
  end

  // Write-port mux; port is driven to zero when idle.
  always_comb begin
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    if (grant_a) begin
      RegWrite  = 1'b1;
      WriteReg  = slot_a.wreg;
      WriteData = slot_a.data;
    end else if (grant_b) begin
      RegWrite  = 1'b1;
      WriteReg  = slot_b.wreg;
      WriteData = slot_b.data;
    end
  end

  // Pending-write vector over FULL slots; the zero register is never busy.
  always_comb begin
    Busy = '0;
    if (!reset) begin
      if (a_full) Busy = Busy | reg_onehot(slot_a.wreg);
      if (b_full) Busy = Busy | reg_onehot(slot_b.wreg);
    end
    Busy[ZERO_REG] = 1'b0;
  end

`ifdef RF_WR_STATS_EN
  logic [CNT_W-1:0] write_count_q;
  logic [CNT_W-1:0] write_count_d;
  logic [CNT_W-1:0] conflict_count_q;
  logic [CNT_W-1:0] conflict_count_d;

  // Saturating write and conflict counters.
  always_comb begin
    write_count_d    = write_count_q;
    conflict_count_d = conflict_count_q;
    if (RegWrite && (write_count_q != '1)) begin
      write_count_d = write_count_q + CNT_W'(1);
    end
    if (a_full && b_full && (conflict_count_q != '1)) begin
      conflict_count_d = conflict_count_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_count_q    <= '0;
      conflict_count_q <= '0;
    end else begin
      write_count_q    <= write_count_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign WriteCount    = write_count_q;
  assign ConflictCount = conflict_count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with a per-register write scoreboard.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic        AValid;
  logic        AReady;
  logic [4:0]  AReg;
  logic [63:0] AData;
  logic        BValid;
  logic        BReady;
  logic [4:0]  BReg;
  logic [63:0] BData;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [31:0] Busy;
`ifdef RF_WR_STATS_EN
  logic [31:0] WriteCount;
  logic [31:0] ConflictCount;
`endif

  regfile_write_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .AValid    (AValid),
    .AReady    (AReady),
    .AReg      (AReg),
    .AData     (AData),
    .BValid    (BValid),
    .BReady    (BReady),
    .BReg      (BReg),
    .BData     (BData),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .Busy      (Busy)
`ifdef RF_WR_STATS_EN
    ,
    .WriteCount    (WriteCount),
    .ConflictCount (ConflictCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  areg;
    logic [63:0] adata;
    logic        bv;
    logic [4:0]  breg;
    logic [63:0] bdata;
    logic        e_ar;
    logic        e_br;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } wr_t;

  vec_t        vecs[$];
  wr_t         sb[$];
  logic [63:0] shadow[32];
  int          errors;
  int          checks;
  int          cur_row;

  function automatic logic [31:0] bt(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  task automatic add(input int rst, input int av, input int areg, input logic [63:0] adata,
                     input int bv, input int breg, input logic [63:0] bdata,
                     input int e_ar, input int e_br, input int e_rw, input int e_wreg,
                     input logic [31:0] e_busy);
    vec_t v;
    v.rst    = 1'(rst);
    v.av     = 1'(av);
    v.areg   = 5'(areg);
    v.adata  = adata;
    v.bv     = 1'(bv);
    v.breg   = 5'(breg);
    v.bdata  = bdata;
    v.e_ar   = 1'(e_ar);
    v.e_br   = 1'(e_br);
    v.e_rw   = 1'(e_rw);
    v.e_wreg = 5'(e_wreg);
    v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, cur_row, act, exp);
    end
  endtask

  // Match an observed write against the oldest pending entry for that register.
  task automatic sb_write(input logic [4:0] r, input logic [63:0] d);
    int idx;
    idx = -1;
    for (int j = 0; j < sb.size(); j++) begin
      if (idx < 0 && sb[j].r == r) idx = j;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write row %0d: got reg %0d data 0x%0h, required no write", cur_row, r, d);
    end else begin
      chk("write_data", d, sb[idx].d);
      sb.delete(idx);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cur_row = 0;
    reset   = 1'b1;
    AValid  = 1'b0;
    AReg    = '0;
    AData   = '0;
    BValid  = 1'b0;
    BReg    = '0;
    BData   = '0;
    for (int r = 0; r < 32; r++) shadow[r] = '0;

    // Reset and idle.
    add(1, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // A alone: R5.
    add(0, 1, 5, 64'h1111, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 5, bt(5));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // Simultaneous accept, different registers: A first (Ptr=A).
    add(0, 1, 1, 64'hA, 1, 2, 64'hB, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 0, 1, 1, bt(1) | bt(2));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 2, bt(2));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // Same register, Ptr=B: older A still drains first.
    add(0, 1, 7, 64'h1, 1, 7, 64'h2, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 0, 1, 7, bt(7));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 7, bt(7));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // B refills R7 while A (R7) is blocked by contention: A must stay older.
    add(0, 1, 7, 64'h3, 1, 8, 64'h8, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 1, 7, 64'h4, 0, 1, 1, 8, bt(7) | bt(8));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 0, 1, 7, bt(7));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 7, bt(7));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // Zero register: handshake completes, nothing written.
    add(0, 1, 31, 64'hDEAD, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // Sustained contention: A regs 1.., B regs 12.., alternating grants.
    for (int k = 0; k < 9; k++) begin
      int ai;
      int bi;
      int sa;
      int sbi;
      logic [31:0] bz;
      ai  = (k == 0) ? 0 : k / 2 + 1;
      bi  = (k + 1) / 2;
      sa  = k / 2;
      sbi = (k == 0) ? 0 : (k - 1) / 2;
      bz  = (k == 0) ? 32'h0 : (bt(1 + sa) | bt(12 + sbi));
      add(0, 1, 1 + ai, 64'hA00 + 64'(ai), 1, 12 + bi, 64'hB00 + 64'(bi),
          int'(k == 0 || k % 2 == 1), int'(k == 0 || k % 2 == 0), int'(k != 0),
          (k % 2 == 1) ? 1 + sa : 12 + sbi, bz);
    end
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 0, 1, 5, bt(5) | bt(16));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 16, bt(16));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    // Reset while both slots FULL: writes discarded, Ptr back to A.
    add(0, 1, 20, 64'hE, 1, 21, 64'hF, 1, 1, 0, 0, 32'h0);
    add(1, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);
    add(0, 1, 3, 64'h33, 1, 4, 64'h44, 1, 1, 0, 0, 32'h0);
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 0, 1, 3, bt(3) | bt(4));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 1, 4, bt(4));
    add(0, 0, 0, 64'h0, 0, 0, 64'h0, 1, 1, 0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      cur_row = i;
      reset   = vecs[i].rst;
      AValid  = vecs[i].av;
      AReg    = vecs[i].areg;
      AData   = vecs[i].adata;
      BValid  = vecs[i].bv;
      BReg    = vecs[i].breg;
      BData   = vecs[i].bdata;
      #1;
      if (vecs[i].rst) sb.delete();
      chk("a_ready", 64'(AReady), 64'(vecs[i].e_ar));
      chk("b_ready", 64'(BReady), 64'(vecs[i].e_br));
      chk("reg_write", 64'(RegWrite), 64'(vecs[i].e_rw));
      chk("busy", 64'(Busy), 64'(vecs[i].e_busy));
      if (RegWrite) begin
        if (vecs[i].e_rw) chk("write_reg", 64'(WriteReg), 64'(vecs[i].e_wreg));
        shadow[WriteReg] = WriteData;
        sb_write(WriteReg, WriteData);
      end else begin
        chk("idle_port", {59'(WriteData != 64'h0), WriteReg}, 64'h0);
      end
      if (vecs[i].av && vecs[i].e_ar && vecs[i].areg != 5'd31) begin
        wr_t w;
        w.r = vecs[i].areg;
        w.d = vecs[i].adata;
        sb.push_back(w);
      end
      if (vecs[i].bv && vecs[i].e_br && vecs[i].breg != 5'd31) begin
        wr_t w;
        w.r = vecs[i].breg;
        w.d = vecs[i].bdata;
        sb.push_back(w);
      end
    end

    @(negedge clock);
    cur_row = vecs.size();
    chk("r7_final", shadow[7], 64'h4);
    chk("r20_discarded", shadow[20], 64'h0);
    chk("r21_discarded", shadow[21], 64'h0);
    chk("r31_never", shadow[31], 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
